// File: rtl/gpr_pkg.sv
// gpr_pkg: shared types and constants for the general-purpose register bank.
//   gpr_state_e : bulk-clear sequencer states (IDLE, CLEAR)
//   GPR_*       : default geometry (32-bit data, 13 registers, 2 read ports)
//   gpr_aw()    : address width for a given depth, never narrower than 1 bit
package gpr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } gpr_state_e;

    localparam int GPR_WIDTH = 32;
    localparam int GPR_DEPTH = 13;
    localparam int GPR_NRD   = 2;

    function automatic int gpr_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/gpr_bank_if.sv
// gpr_bank_if: bus between the decode/control unit (master) and the register bank (slave).
//   GPRLOAD/wr_addr/GPR_data/wr_ready : write channel
//   rd_addr/rd_data/rd_pending        : NRD combinational read ports
//   rsv_en/rsv_addr                   : mark a register as awaiting a producer
//   clr_req/busy                      : bulk-clear request and its in-progress flag
//   dbg_state                         : clear sequencer state, for observation only
//
// Write handshake: a write transfers at a rising edge when GPRLOAD and wr_ready are
// both high. wr_ready never depends on GPRLOAD. A write offered while wr_ready is low
// is dropped, not held: the master must re-issue it once wr_ready returns.
interface gpr_bank_if
    import gpr_pkg::*;
#(
    parameter int WIDTH = GPR_WIDTH,
    parameter int DEPTH = GPR_DEPTH,
    parameter int NRD   = GPR_NRD,
    parameter int AW    = gpr_aw(DEPTH)
);
    logic                        GPRLOAD;
    logic [AW-1:0]               wr_addr;
    logic [WIDTH-1:0]            GPR_data;
    logic                        wr_ready;
    logic [NRD-1:0][AW-1:0]      rd_addr;
    logic [NRD-1:0][WIDTH-1:0]   rd_data;
    logic [NRD-1:0]              rd_pending;
    logic                        rsv_en;
    logic [AW-1:0]               rsv_addr;
    logic                        clr_req;
    logic                        busy;
    gpr_state_e                  dbg_state;

    modport master (
        output GPRLOAD, wr_addr, GPR_data, rd_addr, rsv_en, rsv_addr, clr_req,
        input  wr_ready, rd_data, rd_pending, busy, dbg_state
    );

    modport slave (
        input  GPRLOAD, wr_addr, GPR_data, rd_addr, rsv_en, rsv_addr, clr_req,
        output wr_ready, rd_data, rd_pending, busy, dbg_state
    );
endinterface

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: one pending bit per register for hazard detection.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   set_en_i/set_addr_i : mark a register pending (a new producer has been issued)
//   clr_en_i/clr_addr_i : the producer has written back, drop the pending bit
//   flush_i             : clear every pending bit
//   rd_addr_i           : NRD lookup addresses
//   rd_pending_o        : pending bit per lookup, 0 for addresses beyond DEPTH
module gpr_scoreboard #(
    parameter int DEPTH = 13,
    parameter int NRD   = 2,
    parameter int AW    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   set_en_i,
    input  logic [AW-1:0]          set_addr_i,
    input  logic                   clr_en_i,
    input  logic [AW-1:0]          clr_addr_i,
    input  logic                   flush_i,
    input  logic [NRD-1:0][AW-1:0] rd_addr_i,
    output logic [NRD-1:0]         rd_pending_o
);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] pend_q, pend_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    // Set is applied after clear so a reserve in the same cycle as a write-back
    // leaves the register pending: the new producer is still outstanding.
    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = '0;
        end else begin
            if (clr_en_i && in_range(clr_addr_i)) pend_d[clr_addr_i] = 1'b0;
            if (set_en_i && in_range(set_addr_i)) pend_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    always_comb begin
        rd_pending_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (in_range(rd_addr_i[k])) rd_pending_o[k] = pend_q[rd_addr_i[k]];
        end
    end
endmodule

// File: rtl/gpr_bank.sv
// gpr_bank: parametrised general-purpose register file.
//   clk_50 : system clock, all state changes on the rising edge
//   rst    : synchronous active-high reset, overrides everything including a clear
//   bus    : gpr_bank_if slave port (write, NRD reads, reserve, bulk clear)
// Reads are combinational with optional write-first bypass. A bulk clear zeroes one
// register per cycle for DEPTH cycles; writes and reserves are dropped meanwhile.
module gpr_bank
    import gpr_pkg::*;
#(
    parameter int WIDTH    = GPR_WIDTH,
    parameter int DEPTH    = GPR_DEPTH,
    parameter int NRD      = GPR_NRD,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int AW       = gpr_aw(DEPTH)
) (
    input logic       clk_50,
    input logic       rst,
    gpr_bank_if.slave bus
);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    // An address is live when it names a real register that is not the hard-wired zero.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    gpr_state_e       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             idle;
    logic             wr_fire;
    logic             rsv_fire;
    logic             flush;

    assign idle          = (state_q == IDLE);
    assign bus.wr_ready  = idle;
    assign bus.busy      = !idle;
    assign bus.dbg_state = state_q;

    // Gating with rst keeps a write offered during reset from reaching the bypass path.
    assign wr_fire  = !rst && idle && bus.GPRLOAD && addr_live(bus.wr_addr);
    assign rsv_fire = !rst && idle && bus.rsv_en  && addr_live(bus.rsv_addr);

    // Clear sequencer: next state and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    flush   = 1'b1;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Writes only happen in IDLE and clearing only in CLEAR, so the two never collide.
    // A write in the cycle clr_req is sampled lands and is then swept by the sequence.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            if (wr_fire)            regs_q[bus.wr_addr] <= bus.GPR_data;
            if (state_q == CLEAR)   regs_q[cnt_q]       <= '0;
        end
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            bus.rd_data[k] = '0;
            if (addr_live(bus.rd_addr[k])) begin
                if ((BYPASS != 0) && wr_fire && (bus.wr_addr == bus.rd_addr[k]))
                    bus.rd_data[k] = bus.GPR_data;
                else
                    bus.rd_data[k] = regs_q[bus.rd_addr[k]];
            end
        end
    end

    gpr_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i        (clk_50),
        .rst_i        (rst),
        .set_en_i     (rsv_fire),
        .set_addr_i   (bus.rsv_addr),
        .clr_en_i     (wr_fire),
        .clr_addr_i   (bus.wr_addr),
        .flush_i      (flush),
        .rd_addr_i    (bus.rd_addr),
        .rd_pending_o (bus.rd_pending)
    );
endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised general-purpose register file for the complex CPU. It is the next-generation replacement for the fixed 13 x 32-bit GPR circuit, with separate write and read addressing, N read ports, optional hard-wired zero register, write-first bypass, a per-register pending scoreboard for hazard detection, and a sequenced bulk-clear. It sits between the decode/control unit, which issues addresses, reserve and clear requests, and the ALU/writeback path.

## Interface
- WIDTH, 32: data width in bits.
- DEPTH, 13: number of registers; need not be a power of two.
- NRD, 2: number of read ports, range 1..4.
- ZERO_REG, 0: if 1, register 0 reads 0 and ignores writes and reserves.
- BYPASS, 1: if 1, a same-cycle write to a read address is forwarded to that read port.
- AW, derived: $clog2(DEPTH), 4 by default.

- clk_50  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- GPRLOAD  in  1  write enable.
- wr_addr  in  AW  write address.
- GPR_data  in  WIDTH  write data.
- wr_ready  out  1  high when a write is accepted; low during CLEAR.
- rd_addr  in  NRD x AW  read addresses.
- rd_data  out  NRD x WIDTH  read data, combinational.
- rd_pending  out  NRD  pending bit of each addressed register.
- rsv_en  in  1  reserve request: mark register pending.
- rsv_addr  in  AW  reserve address.
- clr_req  in  1  start bulk clear.
- busy  out  1  high while the clear sequence runs.

## Operation
- Reset (rst=1 at an edge): all registers 0, all pending bits 0, FSM IDLE, busy=0, wr_ready=1.
  - rd_data and rd_pending read 0 immediately after reset.
  - Reset overrides every other input, including mid-clear.
- Write:
  - GPRLOAD=1 with wr_ready=1 and a valid address writes GPR_data at the edge.
  - The write clears that register's pending bit.
- Read:
  - rd_data[k] = reg[rd_addr[k]], combinational.
  - With BYPASS=1, a same-cycle accepted write to the same address forwards GPR_data instead.
- Out-of-range address (>= DEPTH, e.g. 13..15 by default):
  - Writes and reserves are ignored.
  - Reads return 0, pending 0.
- ZERO_REG=1, address 0:
  - Reads 0 and pending 0.
  - No bypass; writes and reserves are ignored.
- Scoreboard:
  - rsv_en sets pending[rsv_addr] at the edge.
  - If a write and a reserve target the same register in one cycle, pending ends at 1 (the new producer wins) and the data is written.
  - Reserving an already-pending register leaves it at 1.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req=1. The counter loads 0 and all pending bits clear at that edge.
  - In CLEAR, reg[cnt] is zeroed each cycle and cnt increments. After cnt = DEPTH-1 the FSM returns to IDLE.
  - busy=1 and wr_ready=0 throughout CLEAR.
  - GPRLOAD and rsv_en are dropped during CLEAR, not queued.
  - clr_req during CLEAR is ignored.
  - Reads during CLEAR return current contents: registers already cleared read 0, the rest keep their old values.

## Timing
- Read latency 0 cycles (combinational); write visible on the cycle after the edge, or the same cycle via bypass.
- Pending bits update at the edge; rd_pending reflects them combinationally.
- Clear: busy rises the cycle after clr_req is sampled and stays high exactly DEPTH cycles (13 by default). wr_ready returns high on the cycle after the last register clears.
- A clr_req and GPRLOAD in the same IDLE cycle: the write is performed, then cleared in sequence.

## Structure
- Package gpr_pkg holds:
  - the state enum typedef (IDLE, CLEAR);
  - default constants GPR_WIDTH=32, GPR_DEPTH=13, GPR_NRD=2.
- One sub-module, gpr_scoreboard: the DEPTH-bit pending vector with set, clear and flush inputs and NRD lookup ports. The array, bypass and clear FSM stay in gpr_bank.

## Test plan
- Reset: drive rst=1 with GPRLOAD=1 and GPR_data=250 -> every rd_data reads 0, pending 0, busy 0; nothing written.
- Load and readback: write 250..262 to r0..r12 (ZERO_REG=0), then sweep both read ports -> r_i reads 250+i. With ZERO_REG=1, r0 reads 0.
- Bypass and range: write 0x100 to r5 while rd_addr[0]=5 -> rd_data[0]=0x100 in the same cycle. With BYPASS=0 the old value appears that cycle and 0x100 the next. Write to address 14 -> ignored; read of 14 returns 0.
- Scoreboard: reserve r3 -> rd_pending=1 next cycle. Write r3 -> pending 0. Simultaneous write and reserve of r3 -> pending 1 and data updated.
- Clear: load 100..112, pulse clr_req -> busy high exactly 13 cycles. Mid-sequence, r0..r(k-1) read 0 and the rest keep their values. A write during CLEAR is dropped with wr_ready=0. Finally all registers read 0.
- Reset mid-clear: rst at cycle 5 of CLEAR -> next cycle IDLE, busy=0, all registers 0.
